morse_char_decoder: RTL and testbench

Downstream consumer of the Morse capture stage. On each capture strobe it latches the reported element pattern (len, dits_dahs, error, word_end) and translates it to ASCII. It emits one character per capture, plus a space at each word end. Output is through a first-word-fall-through FIFO with a ready/valid handshake toward the display/UART sink.

---
 rtl/morse_char_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_morse_char_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_decoder.sv
// Purpose : turns each Morse capture strobe into an ASCII character (plus a space
//           on word end) and queues it in a first-word-fall-through output FIFO.
// Latency : char pushed on the 1st clk edge after the sampling edge, space 1 edge later.
// Backpr. : out_valid/out_ready toward the sink; a push into a full FIFO (no
//           simultaneous pop) is dropped and sets the sticky overflow flag.
// Ports   : clk/aclr (sync, active-high); ce, char_stb, len, dits_dahs, error,
//           word_end from the capture stage; out_data/out_valid/out_ready to
//           the sink; fifo_level (exact occupancy); overflow (sticky drop flag).
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 8
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 4
`endif

module morse_char_decoder #(
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] UNKNOWN_CHAR = 8'h3F,
  parameter bit         EMIT_SPACE   = 1'b1
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          ce,
  input  logic                          char_stb,
  input  logic [`MORSE_LEN_W-1:0]       len,
  input  logic [`MAX_MORSE_LEN-1:0]     dits_dahs,
  input  logic                          error,
  input  logic                          word_end,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [`MORSE_LEN_W-1:0] MAX_LEN = `MORSE_LEN_W'(5);

  typedef enum logic [1:0] {IDLE, PUSH_CHAR, PUSH_SPACE} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_emitted;
  logic [`MORSE_LEN_W-1:0] r_len;
  logic [4:0]              r_dd;
  logic                    r_err;
  logic                    r_wend;

  logic       w_capture;
  logic       w_need_char;
  logic       w_need_space;
  logic       w_push;
  logic [7:0] w_push_dat;
  logic [4:0] w_code;
  logic [7:0] w_char;
  logic       w_unused_dd;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic          r_overflow;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;

  // Only the five newest element bits can ever matter for decode.
  assign w_unused_dd = ^dits_dahs[`MAX_MORSE_LEN-1:5];

  assign w_capture    = ce & char_stb & (r_state == IDLE);
  // emitted suppresses a second char when the word-end strobe re-reports
  // the pattern that was already decoded at char end.
  assign w_need_char  = ~r_emitted & ((len != '0) | error);
  assign w_need_space = word_end & EMIT_SPACE;

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_dat   = w_char;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          if (w_need_char)       w_next_state = PUSH_CHAR;
          else if (w_need_space) w_next_state = PUSH_SPACE;
          else                   w_next_state = IDLE;
        end
      end
      PUSH_CHAR: begin
        w_push       = 1'b1;
        w_push_dat   = w_char;
        w_next_state = (r_wend & EMIT_SPACE) ? PUSH_SPACE : IDLE;
      end
      PUSH_SPACE: begin
        w_push       = 1'b1;
        w_push_dat   = 8'h20;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_state   <= IDLE;
      r_emitted <= 1'b0;
      r_len     <= '0;
      r_dd      <= '0;
      r_err     <= 1'b0;
      r_wend    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_len  <= len;
        r_dd   <= dits_dahs[4:0];
        r_err  <= error;
        r_wend <= word_end;
        if (w_need_char) r_emitted <= 1'b1;
      end else if (ce && !char_stb && len == '0) begin
        // The capture stage has started a fresh character.
        r_emitted <= 1'b0;
      end
    end
  end

  // Keep only bits [len-1:0]; anything above the first element is ignored.
  assign w_code = r_dd & ~(5'h1F << r_len);

  always_comb begin
    w_char = UNKNOWN_CHAR;
    if (!r_err && r_len <= MAX_LEN) begin
      case ({r_len[2:0], w_code})
        8'b001_00000: w_char = "E";
        8'b001_00001: w_char = "T";
        8'b010_00000: w_char = "I";
        8'b010_00001: w_char = "A";
        8'b010_00010: w_char = "N";
        8'b010_00011: w_char = "M";
        8'b011_00000: w_char = "S";
        8'b011_00001: w_char = "U";
        8'b011_00010: w_char = "R";
        8'b011_00011: w_char = "W";
        8'b011_00100: w_char = "D";
        8'b011_00101: w_char = "K";
        8'b011_00110: w_char = "G";
        8'b011_00111: w_char = "O";
        8'b100_00000: w_char = "H";
        8'b100_00001: w_char = "V";
        8'b100_00010: w_char = "F";
        8'b100_00100: w_char = "L";
        8'b100_00110: w_char = "P";
        8'b100_00111: w_char = "J";
        8'b100_01000: w_char = "B";
        8'b100_01001: w_char = "X";
        8'b100_01010: w_char = "C";
        8'b100_01011: w_char = "Y";
        8'b100_01100: w_char = "Z";
        8'b100_01101: w_char = "Q";
        8'b101_11111: w_char = "0";
        8'b101_01111: w_char = "1";
        8'b101_00111: w_char = "2";
        8'b101_00011: w_char = "3";
        8'b101_00001: w_char = "4";
        8'b101_00000: w_char = "5";
        8'b101_10000: w_char = "6";
        8'b101_11000: w_char = "7";
        8'b101_11100: w_char = "8";
        8'b101_11110: w_char = "9";
        default:      w_char = UNKNOWN_CHAR;
      endcase
    end
  end

  // Output FIFO, first-word-fall-through.
  assign out_valid  = (r_level != '0);
  assign w_full     = (r_level == (PW+1)'(FIFO_DEPTH));
  assign w_pop      = out_valid & out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign out_data   = r_mem[r_rd_ptr];
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_dat;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok)          r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
      if (w_pop)              r_rd_ptr   <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_char_decoder.sv
// Purpose : self-checking bench for morse_char_decoder against a table-driven
//           reference (Morse strings per character) and an expected-output queue.
// Ports   : none; drives every DUT port, clock generated here.
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 8
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 4
`endif

module tb_morse_char_decoder;
  localparam int DEPTH = 16;

  logic                      clk = 1'b0;
  logic                      aclr, ce, char_stb, error, word_end, out_ready;
  logic [`MORSE_LEN_W-1:0]   len;
  logic [`MAX_MORSE_LEN-1:0] dits_dahs;
  logic [7:0]                out_data;
  logic                      out_valid;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      overflow;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pops = 0;
  logic [7:0] exp_q[$];
  bit         m_emitted;
  bit         m_ovf;

  string morse_tbl[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."};

  always #5 clk = ~clk;

  morse_char_decoder #(.FIFO_DEPTH(DEPTH), .UNKNOWN_CHAR(8'h3F), .EMIT_SPACE(1'b1)) dut (
    .clk(clk), .aclr(aclr), .ce(ce), .char_stb(char_stb), .len(len),
    .dits_dahs(dits_dahs), .error(error), .word_end(word_end),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] tbl_char(int i);
    return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
  endfunction

  // Reference: search the Morse string table for a pattern whose first
  // element is at bit n-1 and last at bit 0.
  function automatic logic [7:0] ref_decode(int n, logic [7:0] dd, bit err);
    bit hit;
    if (err || n == 0 || n > 5) return 8'h3F;
    for (int i = 0; i < 36; i++) begin
      if (morse_tbl[i].len() == n) begin
        hit = 1'b1;
        for (int k = 0; k < n; k++)
          if ((morse_tbl[i][k] == "-") != dd[n-1-k]) hit = 1'b0;
        if (hit) return tbl_char(i);
      end
    end
    return 8'h3F;
  endfunction

  function automatic logic [7:0] enc(string s, logic [7:0] base);
    logic [7:0] d;
    int n;
    d = base;
    n = s.len();
    for (int k = 0; k < n; k++) d[n-1-k] = (s[k] == "-");
    return d;
  endfunction

  // Sink side: every accepted head byte is checked against the expected stream.
  always @(negedge clk) begin
    if (!aclr && out_valid && out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) chk("pop_extra", 32'(exp_q.size()), 32'd1);
      else                   chk("pop_data", out_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    ce = 1'b1; char_stb = 1'b0; len = '0;
    tick();
    ce = 1'b0;
    m_emitted = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] c);
    if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else                       exp_q.push_back(c);
  endtask

  task automatic strobe(input int n, input logic [7:0] dd, input bit err, input bit wend);
    ce = 1'b1; char_stb = 1'b1; len = `MORSE_LEN_W'(n);
    dits_dahs = dd; error = err; word_end = wend;
    if (!m_emitted && (n != 0 || err)) begin
      model_push(ref_decode(n, dd, err));
      m_emitted = 1'b1;
    end
    if (wend) model_push(8'h20);
    tick();
    ce = 1'b0; char_stb = 1'b0;
  endtask

  task automatic idle(input int cycles, input bit rnd);
    for (int i = 0; i < cycles; i++) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 7) != 0);
        // ce cycles with a non-empty len must not re-arm the char push.
        if ($urandom_range(0, 3) == 0) begin
          ce = 1'b1; len = `MORSE_LEN_W'($urandom_range(1, 15));
        end else ce = 1'b0;
      end
      tick();
    end
    ce = 1'b0;
  endtask

  task automatic peek_one(input string tag, input int n, input logic [7:0] dd,
                          input bit err, input logic [7:0] expv);
    restart();
    out_ready = 1'b0;
    strobe(n, dd, err, 1'b0);
    tick();
    chk(tag, out_data, expv);
    out_ready = 1'b1;
    idle(3, 1'b0);
  endtask

  int         sel, n, ix, pops0;
  logic [7:0] dd;
  bit         err, wend;

  initial begin
    aclr = 1'b1; ce = 1'b0; char_stb = 1'b0; len = '0; dits_dahs = '0;
    error = 1'b0; word_end = 1'b0; out_ready = 1'b0;
    m_emitted = 1'b0; m_ovf = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    aclr = 1'b0;
    tick();

    // 'A': visible right after the first edge following the sampling edge.
    out_ready = 1'b1;
    strobe(2, 8'hF1, 1'b0, 1'b0);
    chk("a_early_valid", out_valid, 0);
    tick();
    chk("a_valid", out_valid, 1);
    chk("a_data", out_data, 8'h41);
    chk("a_level", fifo_level, 1);
    tick();
    chk("a_drained", fifo_level, 0);

    // 'E' then word end with the same pattern: E and one space only.
    restart();
    pops0 = n_pops;
    strobe(1, 8'h00, 1'b0, 1'b0);
    idle(4, 1'b0);
    strobe(1, 8'h00, 1'b0, 1'b1);
    idle(4, 1'b0);
    chk("e_pop_count", 32'(n_pops - pops0), 2);
    chk("e_level", fifo_level, 0);

    // 'T' with word end: char then space on consecutive edges.
    restart();
    out_ready = 1'b0;
    strobe(1, 8'h01, 1'b0, 1'b1);
    tick();
    chk("t_data", out_data, 8'h54);
    chk("t_level1", fifo_level, 1);
    tick();
    chk("t_level2", fifo_level, 2);
    out_ready = 1'b1;
    idle(4, 1'b0);
    chk("t_drained", fifo_level, 0);

    peek_one("err_len3", 3, 8'h02, 1'b1, 8'h3F);
    peek_one("len6", 6, 8'h2A, 1'b0, 8'h3F);
    peek_one("digit0", 5, 8'hFF, 1'b0, 8'h30);
    peek_one("unmapped4", 4, 8'h0F, 1'b0, 8'h3F);
    peek_one("q_upper_bits", 4, 8'hAD, 1'b0, 8'h51);

    // Overflow: 17 chars into a 16-deep FIFO with the sink stalled.
    out_ready = 1'b0;
    pops0 = n_pops;
    for (int i = 0; i < 17; i++) begin
      restart();
      strobe(morse_tbl[i].len(), enc(morse_tbl[i], 8'h00), 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    chk("ovf_level", fifo_level, 16);
    chk("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    idle(20, 1'b0);
    chk("ovf_pop_count", 32'(n_pops - pops0), 16);
    chk("ovf_sticky", overflow, 1);

    // Reset between the char push and the space push.
    out_ready = 1'b0;
    restart(); strobe(2, 8'h01, 1'b0, 1'b0); idle(2, 1'b0);
    restart(); strobe(4, 8'h08, 1'b0, 1'b0); idle(2, 1'b0);
    restart(); strobe(4, 8'h0A, 1'b0, 1'b1);
    tick();
    chk("clr_pre_level", fifo_level, 3);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    exp_q.delete(); m_emitted = 1'b0; m_ovf = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_level", fifo_level, 0);
    chk("clr_ovf", overflow, 0);
    idle(3, 1'b0);
    chk("clr_no_space", fifo_level, 0);
    strobe(3, 8'h05, 1'b0, 1'b0);
    tick();
    chk("clr_next_char", out_data, 8'h4B);
    out_ready = 1'b1;
    idle(3, 1'b0);

    // Randomized traffic against the reference.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) != 0) restart();
      sel = $urandom_range(0, 15);
      dd = 8'($urandom);
      err = 1'b0;
      if (sel == 0) begin
        err = 1'b1; n = $urandom_range(0, 7);
      end else if (sel < 3) begin
        n = $urandom_range(0, 15);
      end else begin
        ix = $urandom_range(0, 35);
        n = morse_tbl[ix].len();
        dd = enc(morse_tbl[ix], dd);
      end
      wend = ($urandom_range(0, 2) == 0);
      strobe(n, dd, err, wend);
      idle($urandom_range(4, 7), 1'b1);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 200 && fifo_level != 0; i++) tick();
    tick();
    chk("final_level", fifo_level, 0);
    chk("final_pending", 32'(exp_q.size()), 0);
    chk("final_ovf", overflow, 32'(m_ovf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
